// File: rtl/pipe_pkg.sv
// Shared definitions for the operand loader and the downstream
// add/sub/multiply pipeline: data width, pipeline latency and the
// loader state encoding.
package pipe_pkg;

  localparam int N   = 10;
  localparam int LAT = 3;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    LOAD_D = 3'd3,
    ISSUE  = 3'd4
  } ld_state_t;

endpackage

// File: rtl/valid_delay.sv
// LAT-deep shift register that delays a single-bit valid flag by exactly
// LAT clock cycles. Reset empties it, dropping any pulse in flight.
module valid_delay #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr;

  // Shift the valid flag one stage per cycle; reset discards pending pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[LAT-1];

endmodule

// File: rtl/pipe_operand_loader.sv
// Serial operand loader: collects four words (A, B, C, D) from a single
// input stream and issues them as a registered operand set to the
// downstream pipeline, then flags the pipeline result LAT cycles later.
//
// Handshake: a word is transferred on a rising edge where in_valid and
// in_ready are both 1. in_ready is 1 in every LOAD_* state and 0 in ISSUE
// and while rst is asserted; in_valid may drop for any number of cycles
// without disturbing the loader.
module pipe_operand_loader
  import pipe_pkg::*;
#(
  parameter int N   = pipe_pkg::N,
  parameter int LAT = pipe_pkg::LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic [N-1:0] D,
  output logic         out_valid,
  output logic         f_valid,
  output logic [7:0]   issue_cnt,
  output ld_state_t    state_dbg
);

  ld_state_t    state;
  logic [N-1:0] stage_a;
  logic [N-1:0] stage_b;
  logic [N-1:0] stage_c;
  logic         accept;

  // Ready in any load state; gated by rst so nothing is offered during reset.
  assign in_ready  = !rst && (state != ISSUE);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  // Load FSM: steer accepted words to staging, publish the set on word D.
  // A..D only change at issue so the downstream stages see stable operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      stage_a   <= '0;
      stage_b   <= '0;
      stage_c   <= '0;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      out_valid <= 1'b0;
      issue_cnt <= 8'd0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        // Drop the partial set and any word offered this cycle.
        state <= LOAD_A;
      end else begin
        case (state)
          LOAD_A: if (accept) begin
            stage_a <= in_data;
            state   <= LOAD_B;
          end
          LOAD_B: if (accept) begin
            stage_b <= in_data;
            state   <= LOAD_C;
          end
          LOAD_C: if (accept) begin
            stage_c <= in_data;
            state   <= LOAD_D;
          end
          LOAD_D: if (accept) begin
            A         <= stage_a;
            B         <= stage_b;
            C         <= stage_c;
            D         <= in_data;
            out_valid <= 1'b1;
            issue_cnt <= issue_cnt + 8'd1;
            state     <= ISSUE;
          end
          ISSUE:   state <= LOAD_A;
          default: state <= LOAD_A;
        endcase
      end
    end
  end

  // Result-valid tracker: the issue pulse re-emerges LAT cycles later.
  valid_delay #(
    .LAT (LAT)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (out_valid),
    .dout (f_valid)
  );

endmodule
